// File: rtl/sim_run_ctrl_pkg.sv
// Shared state encoding and default budgets for the bench run controller.
package sim_run_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int          DEF_CNT_W    = 32;
   localparam logic [31:0] DEF_LIMIT    = 32'h0040_0000;
   localparam logic [31:0] DEF_INTERVAL = 32'd1000000;

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Control and status bundle between a bench top (master) and the run controller (slave).
interface sim_run_ctrl_if #(
   parameter int CNT_W = sim_run_pkg::DEF_CNT_W
);
   import sim_run_pkg::*;

   logic             start;
   logic             pause;
   logic             abort;
   logic             limit_valid;
   logic [CNT_W-1:0] limit;
   logic [CNT_W-1:0] interval;
   logic             use_default_iv;
   state_t           state;
   logic [CNT_W-1:0] count;
   logic             progress_tick;
   logic             done;
   logic             finish_req;

   modport master (
      output start, pause, abort, limit_valid, limit, interval, use_default_iv,
      input  state, count, progress_tick, done, finish_req
   );

   modport slave (
      input  start, pause, abort, limit_valid, limit, interval, use_default_iv,
      output state, count, progress_tick, done, finish_req
   );

endinterface

// File: rtl/sim_run_ctrl_interval_ticker.sv
// Progress sub-counter: latches the interval on load and pulses tick every interval increments.
// Tick is registered on the same edge as the matching increment; an interval of 0 never ticks.
module interval_ticker
   import sim_run_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   input  logic             clear,
   input  logic [CNT_W-1:0] iv_in,
   output logic             tick
);

   logic [CNT_W-1:0] eff_iv;
   logic [CNT_W-1:0] sub;
   logic [CNT_W-1:0] sub_nxt;

   assign sub_nxt = sub + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eff_iv <= '0;
         sub    <= '0;
         tick   <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clear) begin
            sub <= '0;
         end else if (load) begin
            eff_iv <= iv_in;
            sub    <= '0;
         end else if (inc && (eff_iv != '0)) begin
            // sub never passes eff_iv, so the equality test cannot be skipped over
            if (sub_nxt == eff_iv) begin
               sub  <= '0;
               tick <= 1'b1;
            end else begin
               sub <= sub_nxt;
            end
         end
      end
   end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: counts cycles against a latched budget, emits progress ticks and a finish pulse.
// All outputs registered; start is honoured only in IDLE/DONE, abort wins over everything.
module sim_run_ctrl
   import sim_run_pkg::*;
#(
   parameter int               CNT_W            = DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_LIMIT    = CNT_W'(DEF_LIMIT),
   parameter logic [CNT_W-1:0] DEFAULT_INTERVAL = CNT_W'(DEF_INTERVAL)
) (
   input logic           clk,
   input logic           rst,
   sim_run_ctrl_if.slave bus
);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] eff_limit;
   logic [CNT_W-1:0] eff_limit_in;
   logic [CNT_W-1:0] eff_iv_in;
   logic             done;
   logic             finish_req;
   logic             start_go;
   logic             inc;
   logic             tick;

   assign eff_limit_in = bus.limit_valid ? bus.limit : DEFAULT_LIMIT;
   assign eff_iv_in    = (bus.interval != '0) ? bus.interval
                       : (bus.use_default_iv ? DEFAULT_INTERVAL : '0);
   assign count_nxt    = count + CNT_W'(1);
   assign start_go     = bus.start && !bus.abort && ((state == IDLE) || (state == DONE));
   assign inc          = !bus.abort && (state == RUN) && !bus.pause;

   interval_ticker #(
      .CNT_W (CNT_W)
   ) u_ticker (
      .clk   (clk),
      .rst   (rst),
      .load  (start_go),
      .inc   (inc),
      .clear (bus.abort),
      .iv_in (eff_iv_in),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         eff_limit  <= '0;
         done       <= 1'b0;
         finish_req <= 1'b0;
      end else begin
         finish_req <= 1'b0;
         if (bus.abort) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (bus.start) begin
                     eff_limit <= eff_limit_in;
                     count     <= '0;
                     if (eff_limit_in == '0) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                     end else begin
                        state <= RUN;
                        done  <= 1'b0;
                     end
                  end
               end
               RUN: begin
                  if (bus.pause) begin
                     state <= PAUSE;
                  end else begin
                     count <= count_nxt;
                     // count < eff_limit holds in RUN, so count_nxt cannot wrap
                     if (count_nxt >= eff_limit) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (!bus.pause) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.state         = state;
   assign bus.count         = count;
   assign bus.done          = done;
   assign bus.finish_req    = finish_req;
   assign bus.progress_tick = tick;

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Synthesizable run controller for the cycle-driven benches. It sequences a simulation run: it counts clock cycles against a programmable cycle budget, emits a periodic progress tick, and raises a finish request when the budget is reached. It replaces ad-hoc wait/compare logic in bench tops. Its outputs drive the $display progress hook and the $finish hook in the surrounding bench.

Parameters:
CNT_W, 32, width of cycle counter and limit
DEFAULT_LIMIT, 32'h0040_0000 (1<<22), budget used when limit_valid=0 at start
DEFAULT_INTERVAL, 1000000, progress interval used when interval input is 0 and use_default_iv=1

Ports:
clk  in  1  bench clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run (sampled in IDLE/DONE only)
pause  in  1  level; hold counting while high (RUN/PAUSE only)
abort  in  1  return to IDLE from any state
limit_valid  in  1  1: use limit input; 0: use DEFAULT_LIMIT
limit  in  CNT_W  cycle budget, unsigned
interval  in  CNT_W  progress interval, unsigned; 0 = see use_default_iv
use_default_iv  in  1  when interval=0: 1 uses DEFAULT_INTERVAL, 0 disables progress ticks
state  out  2  0=IDLE 1=RUN 2=PAUSE 3=DONE
count  out  CNT_W  cycles counted in current run
progress_tick  out  1  one-cycle pulse each time count reaches a multiple of interval
done  out  1  level, high while in DONE
finish_req  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, progress_tick=0, done=0, finish_req=0, latched limit/interval=0, interval sub-counter=0.
- Priority per cycle: abort > start > pause.
- IDLE: start=1 at edge N -> latch eff_limit (limit_valid ? limit : DEFAULT_LIMIT) and eff_iv; count<=0; sub-counter<=0; state<=RUN. If eff_limit==0, state<=DONE instead (finish_req pulses in the cycle after edge N).
- RUN: each edge with pause=0: count<=count+1. If count+1 >= eff_limit (unsigned compare), state<=DONE at the same edge. With limit L, count==L and state==DONE after edge N+L; finish_req high for exactly the cycle after edge N+L.
- RUN with pause=1: no increment, state<=PAUSE. PAUSE with pause=0: state<=RUN, no increment that edge; counting resumes next edge.
- Progress: sub-counter increments with count; when sub+1==eff_iv, progress_tick=1 (registered, same edge as the matching count value) and sub<=0. eff_iv==0 -> ticks never fire. The final increment and a tick may coincide; both then assert together.
- DONE: count holds; done=1; start=1 restarts exactly as from IDLE (done drops after that edge). pause is ignored.
- abort (any state): state<=IDLE, count<=0, sub<=0, pulses cleared. abort+start in the same cycle -> IDLE.
- start in RUN/PAUSE is ignored. limit/interval changes mid-run are ignored; they are latched only at start.
- No wrap: count never exceeds eff_limit <= 2^CNT_W-1. The unsigned compare covers limit=all-ones.

Decomposition:
- Package sim_run_pkg: state_t enum (IDLE/RUN/PAUSE/DONE), CNT_W default, DEFAULT_LIMIT, DEFAULT_INTERVAL.
- One sub-module: interval_ticker. It holds the sub-counter and eff_iv latch, takes inputs load/inc/clear, and outputs tick. The FSM plus main counter stays in sim_run_ctrl.

Test Plan:
- Reset mid-RUN at count=7 -> all outputs 0 immediately (async), state=IDLE.
- limit_valid=1, limit=5, interval=2, start at edge 0 -> count 1..5 at edges 1..5; progress_tick after edges 2,4; state=DONE after edge 5; finish_req high one cycle, done stays high.
- limit_valid=0, use_default_iv=1, interval=0 -> run ends at count=4194304; 4 progress ticks, first after count=1000000.
- limit=10, pause high for 3 cycles at count=4 -> count holds 4 during PAUSE; DONE after 10+3+1 total edges; no extra increment.
- limit=0 -> DONE the cycle after start, count=0, finish_req pulse. Then start again with limit=3 -> restarts, count 1..3, second finish_req.
- abort and start together in DONE -> IDLE, count=0. limit=8'hFF (CNT_W=8) -> reaches 255, DONE, no wrap to 0.
